// File: rtl/ark_fetch_seq.sv
// ARK instruction-fetch sequencer: variable-latency imem handshake, valid/ready issue to decode,
// relative/absolute branching, registered halt and saturating retire/cycle counters.
module ark_fetch_seq #(
    parameter int unsigned PC_W   = 8,
    parameter int unsigned INST_W = 10,
    parameter int unsigned TGT_W  = 7,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              branch_taken,
    input  logic              branch_abs,
    input  logic [TGT_W-1:0]  branch_target,
    input  logic              halt_req,
    output logic [PC_W-1:0]   pc,
    output logic              halt,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              count_sat
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_ISSUE  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);

    state_t              state, state_d;
    logic [PC_W-1:0]     pc_d;
    logic [INST_W-1:0]   inst_d;
    logic [CNT_W-1:0]    inst_count_d, cycle_count_d;
    logic                count_sat_d;
    logic                handshake_c;
    logic [PC_W-1:0]     tgt_abs_c, tgt_rel_c;

    assign imem_addr   = pc;
    assign handshake_c = (state == S_ISSUE) && inst_ready;
    assign tgt_abs_c   = PC_W'(branch_target);
    assign tgt_rel_c   = pc + PC_W'($signed(branch_target));

    // Next-state, next-pc and counter update; start overrides everything
    always_comb begin
        state_d       = state;
        pc_d          = pc;
        inst_d        = inst;
        inst_count_d  = inst_count;
        cycle_count_d = cycle_count;
        count_sat_d   = count_sat;

        if (start) begin
            state_d       = S_FETCH;
            pc_d          = '0;
            inst_count_d  = '0;
            cycle_count_d = '0;
            count_sat_d   = 1'b0;
        end else begin
            if (state == S_FETCH || state == S_ISSUE) begin
                if (cycle_count != CNT_MAX) cycle_count_d = cycle_count + CNT_ONE;
                if (cycle_count_d == CNT_MAX) count_sat_d = 1'b1;
            end
            case (state)
                S_FETCH: begin
                    if (imem_valid) begin
                        inst_d  = imem_rdata;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (handshake_c) begin
                        if (inst_count != CNT_MAX) inst_count_d = inst_count + CNT_ONE;
                        if (inst_count_d == CNT_MAX) count_sat_d = 1'b1;
                        if (halt_req) begin
                            state_d = S_HALTED;
                        end else begin
                            state_d = S_FETCH;
                            if (branch_taken && branch_abs) pc_d = tgt_abs_c;
                            else if (branch_taken)          pc_d = tgt_rel_c;
                            else                            pc_d = pc + PC_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and registered outputs; status flags are decoded from the next state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            pc          <= '0;
            inst        <= '0;
            inst_count  <= '0;
            cycle_count <= '0;
            count_sat   <= 1'b0;
            imem_req    <= 1'b0;
            inst_valid  <= 1'b0;
            halt        <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            inst        <= inst_d;
            inst_count  <= inst_count_d;
            cycle_count <= cycle_count_d;
            count_sat   <= count_sat_d;
            imem_req    <= (state_d == S_FETCH);
            inst_valid  <= (state_d == S_ISSUE);
            halt        <= (state_d == S_HALTED);
        end
    end

endmodule
